// File: rtl/quickq_req_arbiter.sv
// Round-robin request front end for the QuickQ priority queue: grants one requester
// at a time, sequences the command into the queue FSM and returns a tagged response.
module quickq_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_op,
    input  logic [NREQ*DW-1:0]         req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [DW-1:0]              rsp_data,
    output logic                       rsp_err,
    output logic                       q_enq,
    output logic                       q_deq,
    output logic [DW-1:0]              q_din,
    input  logic                       q_done,
    input  logic [DW-1:0]              q_dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(DEPTH+1);
    localparam int TW  = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_state_next;
    logic [IDW-1:0]  r_ptr, w_ptr_next;
    logic [IDW-1:0]  r_id, w_id_next;
    logic            r_op, w_op_next;
    logic [TW-1:0]   r_tmo, w_tmo_next;
    logic            r_rsp_valid, w_rsp_valid_next;
    logic [IDW-1:0]  r_rsp_id, w_rsp_id_next;
    logic [DW-1:0]   r_rsp_data, w_rsp_data_next;
    logic            r_rsp_err, w_rsp_err_next;
    logic            r_q_enq, w_q_enq_next;
    logic            r_q_deq, w_q_deq_next;
    logic [DW-1:0]   r_q_din, w_q_din_next;
    logic [CW-1:0]   r_count, w_count_next;
    logic            r_full, r_empty;

    logic            w_any;
    logic [IDW-1:0]  w_win;
    logic            w_grant;
    logic            w_win_op;
    logic [DW-1:0]   w_win_data;
    logic [DW-1:0]   w_slice [NREQ];

    // Search ptr+NREQ down to ptr+1 so the nearest valid requester is assigned last and wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (req_valid[IDW'(idx)]) begin
                w_any = 1'b1;
                w_win = IDW'(idx);
            end
        end
    end

    assign w_grant    = (r_state == S_IDLE) && w_any;
    assign w_win_op   = req_op[w_win];
    assign w_win_data = w_slice[w_win];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_slice[gi]   = req_data[gi*DW +: DW];
            // Gated by rst_n so the grant is also silent while reset is held.
            assign req_ready[gi] = rst_n && w_grant && (w_win == IDW'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_id_next        = r_id;
        w_op_next        = r_op;
        w_tmo_next       = r_tmo;
        w_rsp_valid_next = 1'b0;
        w_rsp_id_next    = r_rsp_id;
        w_rsp_data_next  = r_rsp_data;
        w_rsp_err_next   = r_rsp_err;
        w_q_enq_next     = 1'b0;
        w_q_deq_next     = 1'b0;
        w_q_din_next     = r_q_din;
        w_count_next     = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_id_next = w_win;
                    w_op_next = w_win_op;
                    if ((!w_win_op && r_full) || (w_win_op && r_empty)) begin
                        w_state_next     = S_RESP;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_id_next    = w_win;
                        w_rsp_data_next  = '0;
                        w_rsp_err_next   = 1'b1;
                    end else begin
                        w_state_next = S_ISSUE;
                        w_q_enq_next = !w_win_op;
                        w_q_deq_next = w_win_op;
                        w_q_din_next = w_win_data;
                    end
                end
            end
            S_ISSUE: begin
                w_tmo_next   = '0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (q_done) begin
                    w_state_next     = S_RESP;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_id_next    = r_id;
                    w_rsp_data_next  = r_op ? q_dout : '0;
                    w_rsp_err_next   = 1'b0;
                    if (!r_op && (r_count != CW'(DEPTH)))
                        w_count_next = r_count + CW'(1);
                    else if (r_op && (r_count != '0))
                        w_count_next = r_count - CW'(1);
                end else if (r_tmo == TW'(TIMEOUT-1)) begin
                    w_state_next     = S_RESP;
                    w_rsp_valid_next = 1'b1;
                    w_rsp_id_next    = r_id;
                    w_rsp_data_next  = '0;
                    w_rsp_err_next   = 1'b1;
                end else begin
                    w_tmo_next = r_tmo + TW'(1);
                end
            end
            S_RESP: begin
                w_ptr_next   = r_id;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDW'(NREQ-1);
            r_id        <= '0;
            r_op        <= 1'b0;
            r_tmo       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_q_enq     <= 1'b0;
            r_q_deq     <= 1'b0;
            r_q_din     <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_id        <= w_id_next;
            r_op        <= w_op_next;
            r_tmo       <= w_tmo_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_id    <= w_rsp_id_next;
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_err   <= w_rsp_err_next;
            r_q_enq     <= w_q_enq_next;
            r_q_deq     <= w_q_deq_next;
            r_q_din     <= w_q_din_next;
            r_count     <= w_count_next;
            r_full      <= (w_count_next == CW'(DEPTH));
            r_empty     <= (w_count_next == '0);
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign q_enq     = r_q_enq;
    assign q_deq     = r_q_deq;
    assign q_din     = r_q_din;
    assign count     = r_count;
    assign full      = r_full;
    assign empty     = r_empty;
endmodule

// File: tb/tb_quickq_req_arbiter.sv
// Directed bench for quickq_req_arbiter: grant order, rejection, fill/drain,
// timeout, stray q_done and asynchronous reset in mid-operation.
module tb_quickq_req_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_op = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic              q_enq;
    logic              q_deq;
    logic [DW-1:0]     q_din;
    logic              q_done = 1'b0;
    logic [DW-1:0]     q_dout = '0;
    logic [4:0]        count;
    logic              full;
    logic              empty;

    int tests = 0;
    int fails = 0;

    quickq_req_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .q_enq(q_enq), .q_deq(q_deq), .q_din(q_din), .q_done(q_done), .q_dout(q_dout),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Occupancy must never leave 0..DEPTH.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (count <= 5'(DEPTH)) else begin
                fails++;
                $error("FAIL count_sat: observed %0d required <= %0d", count, DEPTH);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        q_done = 1'b0;
        q_dout = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One request from requester id; q_done comes 'delay' cycles after the command pulse.
    task automatic do_op(input int id, input logic op, input logic [31:0] data, input int delay,
                         input logic [31:0] dout, input logic rej, input logic [31:0] exp_data,
                         input int exp_count, input string tag);
        @(posedge clk) #1;
        req_valid[id] = 1'b1;
        req_op[id]    = op;
        req_data[id*DW +: DW] = data;
        @(negedge clk);
        chk({tag, ".grant"}, 64'(req_ready), 64'(1 << id));
        @(posedge clk) #1;
        req_valid[id] = 1'b0;
        @(negedge clk);
        if (rej) begin
            chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(1));
            chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(id));
            chk({tag, ".no_cmd"}, 64'({q_enq, q_deq}), 64'(0));
            chk({tag, ".count"}, 64'(count), 64'(exp_count));
        end else begin
            chk({tag, ".q_enq"}, 64'(q_enq), 64'(!op));
            chk({tag, ".q_deq"}, 64'(q_deq), 64'(op));
            if (!op) chk({tag, ".q_din"}, 64'(q_din), 64'(data));
            repeat (delay) @(posedge clk);
            #1;
            q_done = 1'b1;
            q_dout = dout;
            @(posedge clk) #1;
            q_done = 1'b0;
            @(negedge clk);
            chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(0));
            chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(id));
            chk({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_data));
            chk({tag, ".count"}, 64'(count), 64'(exp_count));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int exp_id;
        // Reset values
        #1 rst_n = 1'b0;
        #11;
        chk("rst.req_ready", 64'(req_ready), 64'(0));
        chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst.rsp_id", 64'(rsp_id), 64'(0));
        chk("rst.rsp_data", 64'(rsp_data), 64'(0));
        chk("rst.rsp_err", 64'(rsp_err), 64'(0));
        chk("rst.q_cmd", 64'({q_enq, q_deq}), 64'(0));
        chk("rst.q_din", 64'(q_din), 64'(0));
        chk("rst.count", 64'(count), 64'(0));
        chk("rst.full", 64'(full), 64'(0));
        chk("rst.empty", 64'(empty), 64'(1));
        @(posedge clk) #1 rst_n = 1'b1;

        // First enqueue from requester 0
        do_op(0, 1'b0, 32'h10, 3, 32'h0, 1'b0, 32'h0, 1, "enq0");
        chk("enq0.empty", 64'(empty), 64'(0));
        chk("enq0.full", 64'(full), 64'(0));

        // Round robin with all four holding enqueues
        do_reset();
        req_op = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'h100 + i;
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            exp_id = n % NREQ;
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (req_ready == '0 && c < 20);
            chk("rr.grant", 64'(req_ready), 64'(1 << exp_id));
            @(posedge clk) #1;
            @(negedge clk);
            chk("rr.q_enq", 64'(q_enq), 64'(1));
            chk("rr.q_din", 64'(q_din), 64'(32'h100 + exp_id));
            @(posedge clk) #1 q_done = 1'b1;
            @(posedge clk) #1 q_done = 1'b0;
            @(negedge clk);
            chk("rr.rsp_id", 64'({rsp_valid, rsp_id}), 64'({1'b1, 2'(exp_id)}));
            chk("rr.count", 64'(count), 64'(n + 1));
        end
        @(posedge clk) #1 req_valid = '0;

        // Dequeue while empty
        do_reset();
        do_op(1, 1'b1, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0, "deq_empty");
        @(negedge clk);
        chk("deq_empty.after", 64'({rsp_valid, q_deq, empty}), 64'(3'b001));

        // Fill to DEPTH, reject a further enqueue, then dequeue one
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            do_op(0, 1'b0, 32'(i), 1, 32'h0, 1'b0, 32'h0, i + 1, "fill");
        chk("fill.full", 64'(full), 64'(1));
        do_op(2, 1'b0, 32'h55, 0, 32'h0, 1'b1, 32'h0, DEPTH, "enq_full");
        chk("enq_full.full", 64'(full), 64'(1));
        chk("enq_full.rsp_data", 64'(rsp_data), 64'(0));
        do_op(3, 1'b1, 32'h0, 2, 32'h7, 1'b0, 32'h7, DEPTH - 1, "deq7");
        chk("deq7.full", 64'(full), 64'(0));

        // Timeout with q_done withheld
        @(posedge clk) #1;
        req_valid[1] = 1'b1;
        req_op[1] = 1'b0;
        req_data[1*DW +: DW] = 32'hABCD;
        @(negedge clk);
        chk("tmo.grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk) #1 req_valid[1] = 1'b0;
        repeat (256) @(negedge clk);
        chk("tmo.early", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        chk("tmo.rsp", 64'({rsp_valid, rsp_err, rsp_id}), 64'({1'b1, 1'b1, 2'd1}));
        chk("tmo.rsp_data", 64'(rsp_data), 64'(0));
        chk("tmo.count", 64'(count), 64'(DEPTH - 1));

        // Stray q_done while idle
        @(posedge clk) #1;
        q_done = 1'b1;
        q_dout = 32'hDEAD;
        @(posedge clk) #1 q_done = 1'b0;
        @(negedge clk);
        chk("stray.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("stray.count", 64'(count), 64'(DEPTH - 1));
        do_op(2, 1'b1, 32'h0, 1, 32'h99, 1'b0, 32'h99, DEPTH - 2, "post_stray");

        // Asynchronous reset in WAIT
        @(posedge clk) #1;
        req_valid[1] = 1'b1;
        req_op[1] = 1'b0;
        req_data[1*DW +: DW] = 32'h77;
        @(negedge clk);
        chk("rstw.grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk) #1 req_valid[1] = 1'b0;
        @(posedge clk) #2 rst_n = 1'b0;
        #1;
        chk("rstw.rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rstw.q_din", 64'(q_din), 64'(0));
        chk("rstw.count", 64'({count, full, empty}), 64'({5'd0, 1'b0, 1'b1}));
        req_op = '0;
        req_data[0*DW +: DW] = 32'h5;
        req_valid = 4'b0011;
        q_done = 1'b1;
        #1;
        chk("rstw.req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("rstw.no_rsp", 64'({rsp_valid, q_enq}), 64'(0));
        @(posedge clk) #1 q_done = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw.first", 64'(req_ready), 64'(4'b0001));
        chk("rstw.idle_rsp", 64'(rsp_valid), 64'(0));
        @(posedge clk) #1 req_valid = '0;
        @(negedge clk);
        chk("rstw.q_din", 64'({q_enq, q_din}), 64'({1'b1, 32'h5}));
        @(posedge clk) #1 q_done = 1'b1;
        @(posedge clk) #1 q_done = 1'b0;
        @(negedge clk);
        chk("rstw.rsp", 64'({rsp_valid, rsp_err, rsp_id}), 64'({1'b1, 1'b0, 2'd0}));
        chk("rstw.count", 64'(count), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/quickq_req_arbiter.md
# quickq_req_arbiter

Round-robin front end for the QuickQ priority queue. It accepts enqueue and dequeue requests from NREQ independent requesters and grants one at a time. It sequences the granted operation into the QuickQ control FSM using a single-cycle command pulse and a done handshake, then returns a tagged response. It also tracks queue occupancy, so it rejects enqueue-when-full and dequeue-when-empty without touching the queue.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 32, key/data width
- DEPTH, 16, queue capacity in entries
- TIMEOUT, 255, maximum WAIT cycles before an operation is aborted with an error

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request pending; held until its req_ready
- req_op  in  NREQ  per-requester opcode: 0 = enqueue, 1 = dequeue
- req_data  in  NREQ*DW  per-requester enqueue key; slice i is bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant pulse; the request is consumed on this edge
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  $clog2(NREQ)  index of the requester being answered
- rsp_data  out  DW  dequeued key; 0 for enqueue and for errors
- rsp_err  out  1  1 = rejected (full/empty) or timed out
- q_enq  out  1  one-cycle enqueue command to the QuickQ control FSM
- q_deq  out  1  one-cycle dequeue command to the QuickQ control FSM
- q_din  out  DW  key presented with q_enq
- q_done  in  1  operation-complete pulse from the QuickQ control FSM
- q_dout  in  DW  dequeued key, valid while q_done is high
- count  out  $clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick a winner by round-robin, searching ptr+1, ptr+2, … modulo NREQ.
  - Assert req_ready[winner] combinationally. Register the winner's id, op and data.
  - If op is enqueue and full, or op is dequeue and empty: go to RESP with err=1.
  - Otherwise go to ISSUE.
- ISSUE: drive q_enq or q_deq high for exactly one cycle with q_din = captured data. Clear the timeout counter. Go to WAIT.
- WAIT:
  - q_done is sampled only in this state.
  - On q_done: capture q_dout if the op is dequeue. Update count (+1 for enqueue, −1 for dequeue). Go to RESP with err=0.
  - If the timeout counter reaches TIMEOUT with no q_done: go to RESP with err=1, rsp_data 0, count unchanged.
- RESP: pulse rsp_valid with the registered rsp_id, rsp_data and rsp_err. Set ptr to the granted id. Go to IDLE.
- count saturates: it never exceeds DEPTH and never goes below 0. These cases are unreachable given the rejection rules; the bench checks them with assertions.
- req_op and req_data of non-granted requesters are ignored. They may change freely until that requester is granted.
- q_done outside WAIT is ignored. No state change occurs.
- A requester that deasserts req_valid before its grant simply loses its turn. No response is generated for it.

## Timing
- Reset values:
  - Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, q_enq=0, q_deq=0, q_din=0, count=0, full=0, empty=1.
  - Internal: state=IDLE, ptr=NREQ−1, so requester 0 has first priority.
- Accepted op:
  - req_ready is high in cycle T.
  - q_enq or q_deq is high in cycle T+1.
  - q_done arrives in cycle W ≥ T+2.
  - rsp_valid is high in cycle W+1. count, full and empty update on the same edge.
  - Back in IDLE at W+2. The next grant is possible in W+2.
- Rejected op: req_ready at T, rsp_valid at T+1, IDLE at T+2. No q_enq or q_deq is issued.
- Timeout: rsp_valid with rsp_err=1 in cycle T+2+TIMEOUT.
- Throughput: at most one operation in flight. There is no grant while in ISSUE, WAIT or RESP.
- Reset mid-operation: return to IDLE immediately (asynchronously) with the reset values above. Any in-flight response is dropped. The QuickQ datapath shares rst_n, so count=0 stays consistent with it.
- All outputs except req_ready are registered.

## Test plan
- Reset, then requester 0 enqueues 0x0000_0010 with q_done 3 cycles after q_enq → q_enq pulse with q_din=0x10; rsp_valid, rsp_id=0, rsp_err=0, rsp_data=0; count=1, empty=0.
- Requesters 0–3 all hold valid enqueues continuously → grant order 0,1,2,3,0 is checked through the req_ready sequence; no requester is granted twice in a row while others are waiting.
- Dequeue with count=0 → req_ready pulse, then rsp_valid with rsp_err=1 on the next cycle; q_deq never asserted; count stays 0.
- Fill to count=16, then requester 2 enqueues → rsp_err=1, full stays 1. Then a dequeue with q_dout=0x0000_0007 → rsp_data=0x07, count=15, full=0.
- Enqueue accepted and q_done withheld → rsp_err=1 exactly 255 cycles after entering WAIT; count unchanged. A q_done pulse injected during IDLE changes nothing.
- Pull rst_n low during WAIT → all outputs return to reset values immediately; no rsp_valid follows; after release, requester 0 is granted first.
